// File: rtl/multi_channel_block.sv
// multi_channel_block: NUM_CH-channel acquisition with per-channel settings/DAC registers,
// circular sample buffers and a single Tx port streaming the last n samples of each enabled channel.
module multi_channel_block #(
  parameter int NUM_CH = 2,
  parameter int BITS_ADC = 8,
  parameter int BITS_DAC = 10,
  parameter int REG_ADDR_WIDTH = 8,
  parameter int REG_DATA_WIDTH = 16,
  parameter int TX_DATA_WIDTH = 8,
  parameter int RAM_DEPTH = 256,
  parameter logic [REG_ADDR_WIDTH-1:0] ADDR_CH_BASE = 'h10,
  parameter logic [7:0] DEFAULT_CH_SETTINGS = 8'h01,
  parameter logic [BITS_DAC-1:0] DEFAULT_DAC_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*BITS_ADC-1:0]   adc_data_i,
  input  logic                         adc_rdy_i,
  output logic [3*NUM_CH-1:0]          Att_Sel,
  output logic [3*NUM_CH-1:0]          Gain_Sel,
  output logic [NUM_CH-1:0]            DC_Coupling,
  output logic [NUM_CH-1:0]            Channel_On,
  output logic [NUM_CH*BITS_DAC-1:0]   dac_val,
  input  logic                         we,
  input  logic                         rqst_data,
  input  logic [15:0]                  num_samples,
  input  logic [REG_ADDR_WIDTH-1:0]    reg_addr,
  input  logic [REG_DATA_WIDTH-1:0]    reg_data,
  input  logic                         reg_rdy,
  output logic [TX_DATA_WIDTH-1:0]     tx_data,
  output logic                         tx_rdy,
  output logic                         tx_eof,
  input  logic                         tx_ack,
  output logic                         busy
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;
  state_t state;
  logic [7:0] ch_set [NUM_CH];
  logic [BITS_DAC-1:0] dac_reg [NUM_CH];
  logic [BITS_ADC-1:0] mem [NUM_CH][RAM_DEPTH];
  logic [AW-1:0] wr_ptr, rd_base;
  logic [AW:0] valid_cnt, n, idx, n_req;
  logic [NUM_CH-1:0] mask;
  logic [IW-1:0] ch;
  logic [IW:0] first, nxt;
  logic cap, unused_bits;
  // Returns {found, index} of the lowest set bit of m at or above from.
  function automatic logic [IW:0] next_on(input logic [NUM_CH-1:0] m, input logic [IW:0] from);
    next_on = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i] && (IW+1)'(i) >= from) next_on = {1'b1, IW'(i)};
  endfunction
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign Att_Sel[3*g +: 3] = ch_set[g][7:5];
    assign Gain_Sel[3*g +: 3] = ch_set[g][4:2];
    assign DC_Coupling[g] = ch_set[g][1];
    assign Channel_On[g] = ch_set[g][0];
    assign dac_val[g*BITS_DAC +: BITS_DAC] = dac_reg[g];
  end
  assign unused_bits = ^reg_data;
  assign busy = state != IDLE;
  assign cap = state == IDLE && we && adc_rdy_i;
  assign n_req = num_samples > 16'(valid_cnt) ? valid_cnt : (AW+1)'(num_samples);
  assign first = next_on(Channel_On, '0);
  assign nxt = next_on(mask, (IW+1)'(ch) + (IW+1)'(1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_set[i] <= DEFAULT_CH_SETTINGS;
        dac_reg[i] <= DEFAULT_DAC_VALUE;
      end
    end else if (reg_rdy) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (reg_addr == REG_ADDR_WIDTH'(ADDR_CH_BASE + 2*i)) ch_set[i] <= reg_data[7:0];
        if (reg_addr == REG_ADDR_WIDTH'(ADDR_CH_BASE + 2*i + 1)) dac_reg[i] <= reg_data[BITS_DAC-1:0];
      end
    end
  always_ff @(posedge clk)
    if (cap)
      for (int i = 0; i < NUM_CH; i++) mem[i][wr_ptr] <= adc_data_i[i*BITS_ADC +: BITS_ADC];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      valid_cnt <= '0;
      rd_base <= '0;
      n <= '0;
      idx <= '0;
      mask <= '0;
      ch <= '0;
      tx_rdy <= 1'b0;
      tx_eof <= 1'b0;
      tx_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cap) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (valid_cnt != (AW+1)'(RAM_DEPTH)) valid_cnt <= valid_cnt + (AW+1)'(1);
          end
          if (rqst_data && n_req != '0 && first[IW]) begin
            mask <= Channel_On;
            n <= n_req;
            rd_base <= wr_ptr - n_req[AW-1:0];
            ch <= first[IW-1:0];
            idx <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          tx_data <= TX_DATA_WIDTH'(mem[ch][rd_base + idx[AW-1:0]]);
          tx_eof <= idx == n - (AW+1)'(1) && !nxt[IW];
          tx_rdy <= 1'b1;
          state <= SEND;
        end
        SEND: begin
          if (tx_ack) begin
            tx_rdy <= 1'b0;
            tx_eof <= 1'b0;
            if (idx != n - (AW+1)'(1)) begin
              idx <= idx + (AW+1)'(1);
              state <= FETCH;
            end else if (nxt[IW]) begin
              ch <= nxt[IW-1:0];
              idx <= '0;
              state <= FETCH;
            end else state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/multi_channel_block.md
Name: multi_channel_block

Overview:
Parametrised successor of the single-channel acquisition block. Serves NUM_CH analog channels from one register bus and one Tx port. Each channel has its own front-end settings and DAC register, plus its own circular sample buffer. On request, the block streams the last N samples of every enabled channel, one channel after another, lowest index first, with a single EOF at the end of the frame.

Parameters:
NUM_CH, 2, number of channels (1..8)
BITS_ADC, 8, ADC sample width
BITS_DAC, 10, DAC word width
REG_ADDR_WIDTH, 8, register bus address width
REG_DATA_WIDTH, 16, register bus data width
TX_DATA_WIDTH, 8, Tx word width (>= BITS_ADC)
RAM_DEPTH, 256, samples per channel buffer (power of 2)
ADDR_CH_BASE, 8'h10, channel i settings register at ADDR_CH_BASE+2i; DAC register at ADDR_CH_BASE+2i+1
DEFAULT_CH_SETTINGS, 8'h01, settings reset value: {Att[7:5],Gain[4:2],DC[1],On[0]}
DEFAULT_DAC_VALUE, 0, DAC register reset value

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
adc_data_i  in  NUM_CH*BITS_ADC  channel i at [i*BITS_ADC +: BITS_ADC]
adc_rdy_i  in  1  common sample strobe, one cycle per sample set
Att_Sel  out  3*NUM_CH  per-channel attenuator select
Gain_Sel  out  3*NUM_CH  per-channel gain select
DC_Coupling  out  NUM_CH  per-channel coupling
Channel_On  out  NUM_CH  per-channel enable
dac_val  out  NUM_CH*BITS_DAC  per-channel DAC value
we  in  1  capture enable
rqst_data  in  1  readout request (level; acted on only in IDLE)
num_samples  in  16  samples per channel requested
reg_addr  in  REG_ADDR_WIDTH  register bus address
reg_data  in  REG_DATA_WIDTH  register bus data
reg_rdy  in  1  register bus write strobe
tx_data  out  TX_DATA_WIDTH  Tx word (sample zero-extended)
tx_rdy  out  1  Tx word valid
tx_eof  out  1  last word of frame
tx_ack  in  1  Tx word accepted
busy  out  1  readout in progress

Behaviour:
- Reset (rst=0, async): settings registers = DEFAULT_CH_SETTINGS; DAC registers = DEFAULT_DAC_VALUE; wr_ptr=0, valid_cnt=0, state=IDLE; tx_rdy=0, tx_eof=0, tx_data=0, busy=0. A reset during readout aborts it, and tx_rdy falls immediately.
- Registers: when reg_rdy=1 and reg_addr matches, the register loads reg_data (low 8 bits for settings, low BITS_DAC bits for DAC) on that edge. The outputs show the new value on the next cycle. Unmatched addresses are ignored.
- Capture (state IDLE only): on a cycle with we=1 and adc_rdy_i=1, all NUM_CH samples are written at wr_ptr. wr_ptr then increments and wraps modulo RAM_DEPTH. valid_cnt increments and saturates at RAM_DEPTH. Capture is frozen outside IDLE.
- Readout start: in IDLE with rqst_data=1, the block latches mask=Channel_On and n=min(num_samples, valid_cnt). If n=0 or mask=0, it stays in IDLE and emits nothing. Otherwise it sets rd_base=(wr_ptr-n) mod RAM_DEPTH, selects ch = lowest set bit of mask, sets idx=0, and goes to FETCH.
- FETCH (1 cycle, RAM read latency): reads buf[ch][(rd_base+idx) mod RAM_DEPTH] and goes to SEND.
- SEND: tx_rdy=1; tx_data holds the fetched word. tx_eof=1 iff idx=n-1 and ch is the highest set bit of mask. tx_data and tx_eof stay stable until tx_ack.
- On tx_rdy and tx_ack:
  - idx<n-1: idx+1, go to FETCH.
  - else, if a higher enabled channel exists: ch = next set bit, idx=0, go to FETCH.
  - else: go to IDLE.
  - tx_rdy is 0 in FETCH and IDLE.
- tx_ack while tx_rdy=0 is ignored.
- Order: oldest to newest within a channel; channels ascending. Total words = n * popcount(mask).
- busy = (state != IDLE). Changes to Channel_On during readout do not affect the latched mask. Register writes remain accepted in all states.
- Throughput: one word per 2 cycles when tx_ack is held high.

Test Plan:
- Reset/registers: release rst, write 8'hA6 to ADDR_CH_BASE+2 -> ch1 Att=3'b101, Gain=3'b001, DC=1, On=0; ch0 stays at 8'h01; DAC registers are 0.
- Basic readout: NUM_CH=2, both enabled, capture ch0=k, ch1=100+k for k=0..9; num_samples=4 -> words 6,7,8,9,106,107,108,109; tx_eof only on 109.
- Masked channel: ch0 Off, ch1 On, same data, num_samples=3 -> 107,108,109 with eof on 109; ch0 data never sent.
- Wrap/saturation: RAM_DEPTH=256, capture 300 samples (ch0=k mod 256), num_samples=1000 -> n=256, words 44..255 then 0..43, eof on the last word.
- Backpressure: toggle tx_ack randomly -> tx_data/tx_eof stay stable while tx_rdy=1 and tx_ack=0; no word is dropped or duplicated; adc_rdy_i strobes during readout do not change wr_ptr.
- Abort/empty: rqst_data with valid_cnt=0 -> tx_rdy stays 0 and busy stays 0; assert rst mid-frame -> tx_rdy=0 at once, and after release the block is IDLE with valid_cnt=0.
